// File: rtl/csa_add_scheduler.sv
// Round-robin scheduler sharing one WORD-bit adder slice between two requesters,
// performing W-bit additions one word per cycle with a registered carry chain.
module csa_add_scheduler #(
    parameter int unsigned WORD  = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [WORD*WORDS-1:0]   req0_a,
    input  logic [WORD*WORDS-1:0]   req0_b,
    input  logic                    req0_cin,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [WORD*WORDS-1:0]   req1_a,
    input  logic [WORD*WORDS-1:0]   req1_b,
    input  logic                    req1_cin,
    output logic [WORD-1:0]         add_a,
    output logic [WORD-1:0]         add_b,
    output logic                    add_cin,
    input  logic [WORD-1:0]         add_sum,
    input  logic                    add_cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD*WORDS-1:0]   out_sum,
    output logic                    out_cout,
    output logic                    out_id
);

    localparam int unsigned W     = WORD * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic             last_grant;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic             id_reg;
    logic             grant0;
    logic             grant1;
    logic             accept;

    // Arbitration: on a tie, the requester not granted last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state == IDLE)) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (idx == IDX_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Feed the current word to the shared slice; idle the slice otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                if (idx == IDX_W'(i)) begin
                    add_a = a_reg[i*WORD +: WORD];
                    add_b = b_reg[i*WORD +: WORD];
                end
            end
            add_cin = (idx == '0) ? cin_reg : carry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            last_grant <= 1'b1;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            id_reg     <= 1'b0;
        end else begin
            if (accept) begin
                a_reg      <= grant1 ? req1_a : req0_a;
                b_reg      <= grant1 ? req1_b : req0_b;
                cin_reg    <= grant1 ? req1_cin : req0_cin;
                id_reg     <= grant1;
                last_grant <= grant1;
                idx        <= '0;
            end
            if (state == RUN) begin
                for (int i = 0; i < int'(WORDS); i++) begin
                    if (idx == IDX_W'(i)) begin
                        sum_reg[i*WORD +: WORD] <= add_sum;
                    end
                end
                carry_reg <= add_cout;
                idx       <= idx + IDX_W'(1);
            end
        end
    end

    assign out_valid = (state == DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = carry_reg;
    assign out_id    = id_reg;

endmodule

// File: tb/tb_csa_add_scheduler.sv
// Scoreboard bench for csa_add_scheduler: directed operations, expected results
// queued at accept time and checked by an independent output monitor.
module tb_csa_add_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [31:0] req1_a, req1_b;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        out_valid, out_ready, out_cout, out_id;
    logic [31:0] out_sum;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    csa_add_scheduler #(.WORD(8), .WORDS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_id     (out_id)
    );

    // The shared combinational adder slice.
    assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] s, input logic c, input logic id);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.id   = id;
        sb.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a ready; returns at the negedge of the accept cycle.
    task automatic wait_accept(input string name);
        bit ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_accept_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_empty(input string name);
        bit ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_drain_timeout"}, 32'(sb.size()), 32'(0));
    endtask

    // Output monitor: compares every consumed result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("mon_sum", out_sum, e.sum);
                chk("mon_cout", 32'(out_cout), 32'(e.cout));
                chk("mon_id", 32'(out_id), 32'(e.id));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic prev_cout;
        logic id;

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_a     = '0;
        req0_b     = '0;
        req0_cin   = 1'b0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        req1_cin   = 1'b0;
        out_ready  = 1'b0;

        // Reset with a valid request pending: nothing may be accepted.
        step;
        step;
        @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", out_sum, 32'(0));
        chk("rst_cout_id", 32'({out_cout, out_id}), 32'(0));
        chk("rst_add", 32'({add_a, add_b, add_cin}), 32'(0));
        step;
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        step;

        // Carry across a word boundary; latency of accept to out_valid.
        req0_valid = 1'b1;
        req0_a     = 32'h0000_00FF;
        req0_b     = 32'h0000_0001;
        req0_cin   = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        chk("t1_ready0", 32'(req0_ready), 32'(1));
        chk("t1_ready1", 32'(req1_ready), 32'(0));
        push(32'h0000_0100, 1'b0, 1'b0);
        step;
        req0_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t1_latency_c%0d", k), 32'(out_valid), 32'(k == 5));
        end
        step;

        // Full ripple from requester 1: carry chains through every word.
        req1_valid = 1'b1;
        req1_a     = 32'hFFFF_FFFF;
        req1_b     = 32'h0000_0000;
        req1_cin   = 1'b1;
        @(negedge clk);
        chk("t2_ready1", 32'(req1_ready), 32'(1));
        chk("t2_ready0", 32'(req0_ready), 32'(0));
        push(32'h0000_0000, 1'b1, 1'b1);
        step;
        req1_valid = 1'b0;
        prev_cout  = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) chk("t2_cin_first", 32'(add_cin), 32'(1));
            if (k >= 2 && k <= 4) chk($sformatf("t2_carry_chain_c%0d", k), 32'(add_cin), 32'(prev_cout));
            if (k <= 4) chk($sformatf("t2_add_a_c%0d", k), 32'(add_a), 32'h0000_00FF);
            if (k == 5) chk("t2_valid", 32'(out_valid), 32'(1));
            prev_cout = add_cout;
        end
        step;

        // Round-robin with both requesters valid continuously from reset.
        rst_n = 1'b0;
        step;
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 32'h0000_0001;
        req0_b     = 32'h0000_0002;
        req0_cin   = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 32'h0000_0010;
        req1_b     = 32'h0000_0020;
        req1_cin   = 1'b1;
        for (int op = 0; op < 4; op++) begin
            wait_accept($sformatf("t3_op%0d", op));
            id = 1'(op % 2);
            chk($sformatf("t3_op%0d_ready0", op), 32'(req0_ready), 32'(id == 1'b0));
            chk($sformatf("t3_op%0d_ready1", op), 32'(req1_ready), 32'(id == 1'b1));
            if (id) push(32'h0000_0031, 1'b0, 1'b1);
            else    push(32'h0000_0003, 1'b0, 1'b0);
            step;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_empty("t3");
        step;

        // Backpressure: result held while the consumer stalls.
        req0_valid = 1'b1;
        req0_a     = 32'h8000_0000;
        req0_b     = 32'h8000_0001;
        req0_cin   = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);
        chk("t4_ready0", 32'(req0_ready), 32'(1));
        push(32'h0000_0002, 1'b1, 1'b0);
        step;
        req1_valid = 1'b1;
        begin
            bit seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1;
                    break;
                end
                chk($sformatf("t4_busy_ready_c%0d", c), 32'({req0_ready, req1_ready}), 32'(0));
            end
            if (!seen) chk("t4_valid_timeout", 32'(0), 32'(1));
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_hold_valid_%0d", k), 32'(out_valid), 32'(1));
            chk($sformatf("t4_hold_sum_%0d", k), out_sum, 32'h0000_0002);
            chk($sformatf("t4_hold_cout_%0d", k), 32'(out_cout), 32'(1));
            chk($sformatf("t4_hold_ready_%0d", k), 32'({req0_ready, req1_ready}), 32'(0));
            if (k < 3) @(negedge clk);
        end
        step;
        out_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("t4_release_valid", 32'(out_valid), 32'(1));
        step;
        @(negedge clk);
        chk("t4_back_idle", 32'(out_valid), 32'(0));
        step;

        // Reset mid-RUN: the operation is dropped.
        req0_valid = 1'b1;
        req0_a     = 32'hDEAD_BEEF;
        req0_b     = 32'h0000_0001;
        req0_cin   = 1'b0;
        @(negedge clk);
        chk("t5_ready0", 32'(req0_ready), 32'(1));
        step;
        req0_valid = 1'b0;
        step;
        step;
        rst_n = 1'b0;
        step;
        @(negedge clk);
        chk("t5_rst_valid", 32'(out_valid), 32'(0));
        chk("t5_rst_sum", out_sum, 32'(0));
        chk("t5_rst_cout_id", 32'({out_cout, out_id}), 32'(0));
        chk("t5_rst_add", 32'({add_a, add_b, add_cin}), 32'(0));
        chk("t5_rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
        step;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t5_no_valid_c%0d", k), 32'(out_valid), 32'(0));
        end
        step;
        req0_valid = 1'b1;
        req0_a     = 32'h1234_5678;
        req0_b     = 32'h1111_1111;
        req0_cin   = 1'b0;
        @(negedge clk);
        chk("t5_after_ready0", 32'(req0_ready), 32'(1));
        push(32'h2345_6789, 1'b0, 1'b0);
        step;
        req0_valid = 1'b0;
        wait_empty("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_add_scheduler.md
# csa_add_scheduler

Multi-cycle scheduler that shares one combinational WORD-bit carry-select adder slice between two requesters. It performs wide additions (WORD*WORDS bits) by sequencing the slice one word per cycle, least-significant word first, chaining the carry through a register. It sits between the two operand sources and the shared adder/multiplexor datapath. It arbitrates round-robin and returns the result with a requester ID over a valid/ready handshake.

## Interface

Parameters:
- WORD, 8, width of the shared adder slice in bits
- WORDS, 4, number of slice passes per operation; operand width W = WORD*WORDS

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  W  requester 0 operands
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0
- add_a, add_b  output  WORD  operands to the shared adder slice
- add_cin  output  1  carry-in to the shared adder slice
- add_sum  input  WORD  slice sum, combinational from add_a/add_b/add_cin
- add_cout  input  1  slice carry-out
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  W  full sum
- out_cout  output  1  final carry-out
- out_id  output  1  requester that owns the result (0 or 1)

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If either reqN_valid is high, grant one requester. reqN_ready goes high combinationally for the granted requester only. The other ready stays 0.
  - Arbitration: if only one is valid, grant it. If both are valid, grant the requester not granted last time. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On the accept edge: latch a, b, cin and the ID. Set word index idx=0. Update the last-grant pointer. Go to RUN.
- RUN:
  - add_a = a_reg[idx*WORD +: WORD] and add_b = b_reg[idx*WORD +: WORD].
  - add_cin = cin_reg when idx=0, else carry_reg.
  - Each edge: sum_reg[idx*WORD +: WORD] <= add_sum; carry_reg <= add_cout; idx <= idx+1.
  - After the edge that captures idx=WORDS-1, go to DONE.
- DONE:
  - out_valid=1. out_sum=sum_reg, out_cout=carry_reg and out_id=id_reg, all held stable.
  - On the edge where out_ready=1, go to IDLE. No new request is accepted in DONE.
- Outside RUN: add_a, add_b and add_cin are driven to 0.
- Width rule: out_sum is modulo 2^W. The overflow bit appears only on out_cout.
- Backpressure: reqN_ready is 0 in RUN and DONE, whatever reqN_valid is.

## Timing

- Reset (rst_n=0 sampled at an edge):
  - state=IDLE, idx=0, last-grant=1.
  - sum_reg, carry_reg, cin_reg, id_reg, a_reg and b_reg all 0.
  - out_valid=0, out_sum=0, out_cout=0, out_id=0, req0_ready=0, req1_ready=0, add_*=0.
  - Ready outputs are forced to 0 during any cycle where rst_n=0.
- Latency:
  - Accept at edge E0.
  - Words are captured at edges E1..E_WORDS.
  - out_valid is high in the cycle after E_WORDS, i.e. WORDS+1 cycles after the accept cycle.
  - With out_ready held high: DONE lasts 1 cycle, and IDLE can accept on the next cycle.
  - Minimum period: WORDS+2 cycles per operation.
- Reset mid-RUN or mid-DONE: the operation is abandoned. out_valid never asserts for it, the FSM returns to IDLE, and the pointer is reset.
- Simultaneous valid plus reset: reset wins and nothing is accepted.
- reqN_valid dropping while not granted has no effect. Requesters must hold their operands stable only during the accept cycle.
- idx wraps to 0 on entry to RUN and is never read in IDLE or DONE.

## Test plan

- **Single operation, carry across a word boundary.** Stimulus: WORD=8, WORDS=4, req0 a=0x000000FF, b=0x00000001, cin=0. Required: out_sum=0x00000100, out_cout=0, out_id=0, out_valid high exactly 5 cycles after the accept cycle.
- **Full ripple.** Stimulus: req1 a=0xFFFFFFFF, b=0x00000000, cin=1. Required: out_sum=0x00000000, out_cout=1, out_id=1. add_cin must equal the previous cycle's add_cout on RUN cycles 2–4.
- **Round-robin.** Stimulus: both valid continuously from reset, out_ready=1. Required: grant/out_id sequence 0,1,0,1, and exactly one ready high per accept.
- **Backpressure.** Stimulus: out_ready=0 for 3 cycles in DONE, then 1. Required: out_valid, out_sum and out_cout stay stable; both readies stay 0; return to IDLE on the out_ready edge.
- **Reset mid-RUN.** Stimulus: assert rst_n=0 at idx=2. Required: all outputs at reset values and no out_valid. A following req0 a=0x12345678, b=0x11111111 yields 0x23456789 with out_id=0.
